// File: rtl/gcd_controller_if.sv
// Control bundle between the GCD sequencer and its subtract-and-compare datapath.
// The master side owns the run request and the comparator outputs; the slave
// side (the controller) owns mux selects, load enables and status.
interface gcd_controller_if #(
  parameter int unsigned CNT_W = 8
);
  // run control and datapath status into the controller
  logic             start;
  logic             abort;
  logic             flag;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  // datapath steering and status out of the controller
  logic             a_sel;
  logic             b_sel;
  logic             sub_swap;
  logic             a_ld;
  logic             b_ld;
  logic             ld_out;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output start, abort, flag, a_gt_b, a_eq_b, a_lt_b,
    input  a_sel, b_sel, sub_swap, a_ld, b_ld, ld_out, busy, done, error, iter_count
  );

  modport slave (
    input  start, abort, flag, a_gt_b, a_eq_b, a_lt_b,
    output a_sel, b_sel, sub_swap, a_ld, b_ld, ld_out, busy, done, error, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Sequencer for the 8-bit subtract-and-compare GCD datapath.
// IDLE -> LOAD -> COMPUTE (one subtract/reload per cycle) -> DONE or ERR -> IDLE.
// Every finished run ends in exactly one done pulse; error qualifies it for
// invalid operands, iteration timeout or a non-one-hot comparator.
// MAX_ITER must fit in CNT_W bits (2**CNT_W > MAX_ITER).
module gcd_controller #(
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  gcd_controller_if.slave ctl
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] iter_q, iter_nxt;

  logic cmp_ok;
  logic below_max;

  logic a_sel, b_sel, sub_swap;
  logic a_ld, b_ld, ld_out;
  logic busy, done, error;

  // A healthy comparator asserts exactly one of gt/eq/lt.
  assign cmp_ok    = $onehot({ctl.a_gt_b, ctl.a_eq_b, ctl.a_lt_b});
  assign below_max = (cnt < MAX_C);

  // State, step counter and reported iteration count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      iter_q <= iter_nxt;
    end
  end

  // Next state and outputs; COMPUTE outputs are decoded from the comparator.
  // iter_count is captured on entry to DONE/ERR so it is valid with done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    iter_nxt  = iter_q;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    sub_swap  = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    ld_out    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    unique case (state)
      IDLE: begin
        if (ctl.start) begin
          if (ctl.flag) begin
            state_nxt = LOAD;
          end else begin
            // zero operand: report immediately, nothing loaded, zero steps
            state_nxt = ERR;
            iter_nxt  = '0;
          end
        end
      end

      LOAD: begin
        busy    = 1'b1;
        cnt_nxt = '0;
        if (ctl.abort) begin
          state_nxt = IDLE;
        end else begin
          a_sel     = 1'b1;
          b_sel     = 1'b1;
          a_ld      = 1'b1;
          b_ld      = 1'b1;
          state_nxt = COMPUTE;
        end
      end

      COMPUTE: begin
        busy = 1'b1;
        if (ctl.abort) begin
          state_nxt = IDLE;
        end else if (!cmp_ok) begin
          state_nxt = ERR;
          iter_nxt  = cnt;
        end else if (ctl.a_eq_b) begin
          // equality wins even at the limit: the answer is already in A
          ld_out    = 1'b1;
          state_nxt = DONE;
          iter_nxt  = cnt;
        end else if (!below_max) begin
          state_nxt = ERR;
          iter_nxt  = cnt;
        end else if (ctl.a_gt_b) begin
          a_sel    = 1'b0;
          sub_swap = 1'b0;
          a_ld     = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
        end else begin
          b_sel    = 1'b0;
          sub_swap = 1'b1;
          b_ld     = 1'b1;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      ERR: begin
        done      = 1'b1;
        error     = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign ctl.a_sel      = a_sel;
  assign ctl.b_sel      = b_sel;
  assign ctl.sub_swap   = sub_swap;
  assign ctl.a_ld       = a_ld;
  assign ctl.b_ld       = b_ld;
  assign ctl.ld_out     = ld_out;
  assign ctl.busy       = busy;
  assign ctl.done       = done;
  assign ctl.error      = error;
  assign ctl.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: two instances (MAX_ITER 255 and 8) driven with the
// same operands, each closing the loop through its own datapath model.
// Expected timing/results come from Euclid's algorithm, not from the FSM.
module tb_gcd_controller;
  localparam int M0 = 255;
  localparam int M1 = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       fault = 1'b0;
  logic [7:0] d1    = 8'd0;
  logic [7:0] d2    = 8'd0;
  logic       flag;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_controller_if #(.CNT_W(8)) if0 ();
  gcd_controller_if #(.CNT_W(8)) if1 ();

  gcd_controller #(.MAX_ITER(M0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .ctl(if0.slave));
  gcd_controller #(.MAX_ITER(M1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .ctl(if1.slave));

  always #5 clk = ~clk;

  // per-instance views of the outputs
  logic [1:0] ald, bld, asel, bsel, swp, ldo, busy, done, err;
  logic [7:0] iter [2];
  logic [7:0] a_r [2];
  logic [7:0] b_r [2];
  logic [7:0] res_r [2];

  assign ald  = {if1.a_ld,     if0.a_ld};
  assign bld  = {if1.b_ld,     if0.b_ld};
  assign asel = {if1.a_sel,    if0.a_sel};
  assign bsel = {if1.b_sel,    if0.b_sel};
  assign swp  = {if1.sub_swap, if0.sub_swap};
  assign ldo  = {if1.ld_out,   if0.ld_out};
  assign busy = {if1.busy,     if0.busy};
  assign done = {if1.done,     if0.done};
  assign err  = {if1.error,    if0.error};
  assign iter[0] = if0.iter_count;
  assign iter[1] = if1.iter_count;

  assign flag = (d1 != 8'd0) && (d2 != 8'd0);

  assign if0.start  = start;
  assign if0.abort  = abort;
  assign if0.flag   = flag;
  assign if0.a_gt_b = !fault && (a_r[0] >  b_r[0]);
  assign if0.a_eq_b = !fault && (a_r[0] == b_r[0]);
  assign if0.a_lt_b = !fault && (a_r[0] <  b_r[0]);
  assign if1.start  = start;
  assign if1.abort  = abort;
  assign if1.flag   = flag;
  assign if1.a_gt_b = !fault && (a_r[1] >  b_r[1]);
  assign if1.a_eq_b = !fault && (a_r[1] == b_r[1]);
  assign if1.a_lt_b = !fault && (a_r[1] <  b_r[1]);

  // datapath model: A/B registers with muxes, subtractor and result register
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ald[i]) a_r[i] <= asel[i] ? d1 : (swp[i] ? b_r[i] - a_r[i] : a_r[i] - b_r[i]);
      if (bld[i]) b_r[i] <= bsel[i] ? d2 : (swp[i] ? b_r[i] - a_r[i] : a_r[i] - b_r[i]);
      if (ldo[i]) res_r[i] <= a_r[i];
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[inst%0d]: got %0d, expected %0d", nm, i, act, exp);
    end
  endtask

  // Subtractive GCD step count from Euclid: sum of quotients, minus the
  // subtraction that would reach zero instead of equality.
  function automatic void ref_gcd(input int x, input int y, output int n, output int g);
    int r;
    n = -1;
    while (y != 0) begin
      n += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    g = x;
  endfunction

  // One complete run on both instances, checked against n_ref/g_ref.
  task automatic run_check(input logic [7:0] x, input logic [7:0] y, input int n_ref, input int g_ref);
    int e_cyc[2], e_err[2], e_iter[2], e_ldo[2];
    int d_cyc[2], d_cnt[2], l_cnt[2], o_cyc[2], a_err[2], a_iter[2], a_res[2];
    int e_max, mx;
    bit valid;
    valid = (x != 8'd0) && (y != 8'd0);
    e_max = 0;
    for (int i = 0; i < 2; i++) begin
      mx = (i == 0) ? M0 : M1;
      if (!valid) begin
        e_cyc[i] = 1; e_err[i] = 1; e_iter[i] = 0; e_ldo[i] = -1;
      end else if (n_ref <= mx) begin
        e_cyc[i] = n_ref + 3; e_err[i] = 0; e_iter[i] = n_ref; e_ldo[i] = n_ref + 2;
      end else begin
        e_cyc[i] = mx + 3; e_err[i] = 1; e_iter[i] = mx; e_ldo[i] = -1;
      end
      if (e_cyc[i] > e_max) e_max = e_cyc[i];
      d_cyc[i] = -1; d_cnt[i] = 0; l_cnt[i] = 0; o_cyc[i] = -1;
      a_err[i] = -1; a_iter[i] = -1; a_res[i] = -1;
    end
    @(negedge clk);
    d1 = x; d2 = y; start = 1'b1;
    for (int c = 1; c <= e_max + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (ald[i] || bld[i]) l_cnt[i]++;
        if (ldo[i]) o_cyc[i] = c;
        if (done[i]) begin
          d_cnt[i]++;
          if (d_cyc[i] < 0) begin
            d_cyc[i]  = c;
            a_err[i]  = int'(err[i]);
            a_iter[i] = int'(iter[i]);
            a_res[i]  = int'(res_r[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done_cycle(%0d,%0d)", x, y), i, d_cyc[i], e_cyc[i]);
      chk($sformatf("done_pulses(%0d,%0d)", x, y), i, d_cnt[i], 1);
      chk($sformatf("error(%0d,%0d)", x, y), i, a_err[i], e_err[i]);
      chk($sformatf("iter_count(%0d,%0d)", x, y), i, a_iter[i], e_iter[i]);
      chk($sformatf("load_cycles(%0d,%0d)", x, y), i, l_cnt[i], valid ? e_iter[i] + 1 : 0);
      chk($sformatf("ld_out_cycle(%0d,%0d)", x, y), i, o_cyc[i], e_ldo[i]);
      if (e_ldo[i] >= 0) chk($sformatf("result(%0d,%0d)", x, y), i, a_res[i], g_ref);
    end
    for (int k = 0; k < 300 && (busy != 2'b00 || done != 2'b00); k++) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         n;
    int         g;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n, g;
    logic [7:0] x, y;

    tbl[0] = '{8'd36,  8'd24,  2,   12};
    tbl[1] = '{8'd17,  8'd17,  0,   17};
    tbl[2] = '{8'd255, 8'd1,   254, 1};
    tbl[3] = '{8'd100, 8'd3,   35,  1};
    tbl[4] = '{8'd0,   8'd5,   0,   0};
    tbl[5] = '{8'd5,   8'd0,   0,   0};
    tbl[6] = '{8'd24,  8'd36,  2,   12};
    tbl[7] = '{8'd1,   8'd255, 254, 1};
    tbl[8] = '{8'd9,   8'd1,   8,   1};
    tbl[9] = '{8'd10,  8'd1,   9,   1};

    // asynchronous reset: everything low immediately
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", i, int'({asel[i], bsel[i], swp[i], ald[i], bld[i], ldo[i], busy[i], done[i], err[i]}), 0);
      chk("reset_iter", i, int'(iter[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (tbl[k]) run_check(tbl[k].a, tbl[k].b, tbl[k].n, tbl[k].g);

    for (int k = 0; k < 30; k++) begin
      x = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      y = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      n = 0; g = 0;
      if (x != 8'd0 && y != 8'd0) ref_gcd(int'(x), int'(y), n, g);
      run_check(x, y, n, g);
    end

    // abort mid-run: loads drop at once, IDLE next cycle, no done, count kept
    run_check(8'd36, 8'd24, 2, 12);
    @(negedge clk);
    d1 = 8'd255; d2 = 8'd1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == 3);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (c == 2) chk("abort_pre_a_ld", i, int'(ald[i]), 1);
        if (c == 3) chk("abort_loads", i, int'({ald[i], bld[i], ldo[i]}), 0);
        if (c == 4) chk("abort_busy", i, int'(busy[i]), 0);
        if (done[i]) chk($sformatf("abort_no_done_c%0d", c), i, 1, 0);
      end
    end
    abort = 1'b0;
    for (int i = 0; i < 2; i++) chk("abort_iter_kept", i, int'(iter[i]), 2);

    // reset in cycle 5 of a run: outputs clear without waiting for a clock
    @(negedge clk);
    d1 = 8'd255; d2 = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrun_reset_outputs", i, int'({asel[i], bsel[i], swp[i], ald[i], bld[i], ldo[i], busy[i], done[i], err[i]}), 0);
      chk("midrun_reset_iter", i, int'(iter[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_check(8'd36, 8'd24, 2, 12);

    // comparator fault (no bit set) in the first COMPUTE cycle
    fault = 1'b1;
    @(negedge clk);
    d1 = 8'd36; d2 = 8'd24; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (c == 2) chk("fault_no_loads", i, int'({ald[i], bld[i], ldo[i]}), 0);
        if (c == 3) begin
          chk("fault_done", i, int'(done[i]), 1);
          chk("fault_error", i, int'(err[i]), 1);
          chk("fault_iter", i, int'(iter[i]), 0);
        end
        if (c > 3) chk($sformatf("fault_single_done_c%0d", c), i, int'(done[i]), 0);
      end
    end
    fault = 1'b0;

    // start held high: the next run begins right after the done cycle
    @(negedge clk);
    d1 = 8'd17; d2 = 8'd17; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 5) start = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (c == 2) chk("hold_busy_no_restart", i, int'(busy[i]), 1);
        if (c == 3) chk("hold_done1", i, int'(done[i]), 1);
        if (c == 4) chk("hold_idle", i, int'({busy[i], done[i]}), 0);
        if (c == 5) chk("hold_reload", i, int'({ald[i], bld[i]}), 3);
        if (c == 7) chk("hold_done2", i, int'({done[i], err[i]}), 2);
        if (c == 8) chk("hold_after", i, int'({busy[i], done[i]}), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM that sequences the 8-bit subtract-and-compare GCD datapath. It accepts a start request, checks input validity, loads the A/B operand registers, and issues one subtract-and-reload step per cycle until the comparator reports equality. It then loads the result register and signals completion. An iteration limit bounds every run, and every outcome ends in a single done pulse with an error qualifier.

## Interface
- MAX_ITER, 255: maximum subtraction steps per run; reaching it without equality ends the run as an error.
- CNT_W, 8: width of the iteration counter and of iter_count; must satisfy 2^CNT_W > MAX_ITER.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- flag  in  1  datapath validity: 1 = both data_in1 and data_in2 non-zero.
- a_gt_b, a_eq_b, a_lt_b  in  1 each  datapath comparator outputs on registered A/B (one-hot).
- a_sel  out  1  A-register mux: 1 = data_in1, 0 = sub_out.
- b_sel  out  1  B-register mux: 1 = data_in2, 0 = sub_out.
- sub_swap  out  1  subtractor operand order: 0 = A−B, 1 = B−A.
- a_ld, b_ld  out  1 each  A/B register load enables.
- ld_out  out  1  result register load enable (loads A).
- busy  out  1  high in LOAD and COMPUTE.
- done  out  1  one-cycle completion pulse.
- error  out  1  qualifies done: 1 = invalid input, timeout, or comparator fault.
- iter_count  out  CNT_W  subtraction steps taken by the last finished run; held until the next run starts.

## Operation
- States: IDLE, LOAD, COMPUTE, DONE, ERR.
- IDLE to LOAD: start=1 and flag=1.
- IDLE to ERR: start=1 and flag=0. No register loads occur.
- LOAD:
  - Outputs: a_sel=b_sel=1, a_ld=b_ld=1.
  - The iteration counter clears to 0.
  - Always goes to COMPUTE.
- COMPUTE: outputs are decoded from the comparator inputs (Mealy).
  - a_eq_b: ld_out=1; go to DONE.
  - a_gt_b with counter<MAX_ITER: a_sel=0, sub_swap=0, a_ld=1; counter+1; stay in COMPUTE.
  - a_lt_b with counter<MAX_ITER: b_sel=0, sub_swap=1, b_ld=1; counter+1; stay in COMPUTE.
  - Not equal with counter==MAX_ITER: no loads; go to ERR.
  - Comparator not one-hot (none or more than one asserted): no loads; go to ERR.
- DONE: done=1, error=0. iter_count takes the counter value. Go to IDLE.
- ERR: done=1, error=1. iter_count takes the counter value (0 for invalid input). Go to IDLE.
- abort=1 in LOAD or COMPUTE:
  - Next state is IDLE. All load enables are 0 in that cycle.
  - No done pulse; iter_count is unchanged.
  - abort is ignored in IDLE, DONE and ERR.
- start is ignored outside IDLE. If start is held high, a new run begins in the cycle after DONE or ERR.
- Default for every output not listed in a state: 0. The mux selects a_sel, b_sel and sub_swap are don't-care when their load enable is 0; drive them 0.

## Timing
- Reset (rst=0, asynchronous): state goes to IDLE; counter and iter_count go to 0; every output is 0.
  - Reset mid-run discards the run with no done pulse.
  - Release is synchronous to clk.
- Cycle numbering: cycle 0 is the IDLE cycle in which start=1 is sampled.
  - Cycle 1: LOAD.
  - Cycles 2 to N+1: the N subtraction steps.
  - Cycle N+2: ld_out=1.
  - Cycle N+3: done=1.
- Latency from start to done: N+3 cycles. The result register holds the GCD from cycle N+3 on.
- Invalid input: done=error=1 in cycle 1.
- Timeout: done=error=1 in cycle MAX_ITER+3, after exactly MAX_ITER subtractions.
- Back-to-back runs: done in cycle k, IDLE in cycle k+1, a new start may be sampled in cycle k+1.
- Throughput: one subtraction per cycle. Worst legal case (255,1) gives N=254, done at cycle 257.

## Test plan
- (36,24), start for 1 cycle:
  - a_ld in cycle 2, b_ld in cycle 3, ld_out in cycle 4.
  - done=1, error=0 in cycle 5; result 12; iter_count=2.
- (17,17): ld_out in cycle 2; done in cycle 3; result 17; iter_count=0.
- (255,1) with default MAX_ITER: done in cycle 257, error=0, result 1, iter_count=254.
- (100,3) with MAX_ITER=8:
  - 8 a_ld pulses, then no further loads.
  - done=error=1 in cycle 11; iter_count=8.
- (0,5), i.e. flag=0: no a_ld/b_ld; done=error=1 in cycle 1; iter_count=0.
- Interruption:
  - abort in cycle 3 of (255,1): IDLE in cycle 4, no done, busy=0.
  - rst low in cycle 5 of a new run: all outputs 0 at once.
  - After release, (36,24) completes with result 12.
